// File: rtl/pipe_control.sv
// Pipelined MIPS main control: ID decode, ID/EX, EX/MEM and MEM/WB control
// registers, load-use stall detection, branch squash and saturating event counters.
module pipe_control #(
  parameter int ALUOP_W = 2,
  parameter int REG_W   = 5,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               id_valid,
  input  logic [5:0]         id_op,
  input  logic [REG_W-1:0]   id_rs,
  input  logic [REG_W-1:0]   id_rt,
  input  logic               branch_taken,
  output logic [ALUOP_W+1:0] ex_ctrl,
  output logic [REG_W-1:0]   ex_rt,
  output logic [2:0]         mem_ctrl,
  output logic [1:0]         wb_ctrl,
  output logic               stall,
  output logic               ifid_flush,
  output logic               illegal_op,
  output logic [CNT_W-1:0]   stall_count,
  output logic [CNT_W-1:0]   flush_count
);

  localparam int EX_W = ALUOP_W + 2;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;

  logic [EX_W-1:0]  dec_ex_s;
  logic [2:0]       dec_m_s;
  logic [1:0]       dec_wb_s;
  logic             dec_illegal_s;
  logic             reads_rt_s;
  logic             hazard_s;
  logic             stall_s;

  logic [EX_W-1:0]  idex_ex_r;
  logic [2:0]       idex_m_r;
  logic [1:0]       idex_wb_r;
  logic [REG_W-1:0] idex_rt_r;
  logic             idex_illegal_r;
  logic [2:0]       exmem_m_r;
  logic [1:0]       exmem_wb_r;
  logic [1:0]       memwb_wb_r;
  logic [CNT_W-1:0] stall_count_r;
  logic [CNT_W-1:0] flush_count_r;

  // Opcode decode into EX/M/WB bundles; invalid slots decode to all-zero.
  always_comb begin
    dec_ex_s      = '0;
    dec_m_s       = 3'b000;
    dec_wb_s      = 2'b00;
    dec_illegal_s = 1'b0;
    reads_rt_s    = 1'b0;
    if (id_valid) begin
      case (id_op)
        OP_RTYPE: begin
          dec_ex_s   = {1'b1, ALUOP_W'(2'd2), 1'b0};
          dec_wb_s   = 2'b10;
          reads_rt_s = 1'b1;
        end
        OP_LW: begin
          dec_ex_s = {1'b0, ALUOP_W'(2'd0), 1'b1};
          dec_m_s  = 3'b010;
          dec_wb_s = 2'b11;
        end
        OP_SW: begin
          dec_ex_s   = {1'b0, ALUOP_W'(2'd0), 1'b1};
          dec_m_s    = 3'b001;
          reads_rt_s = 1'b1;
        end
        OP_BEQ: begin
          dec_ex_s   = {1'b0, ALUOP_W'(2'd1), 1'b0};
          dec_m_s    = 3'b100;
          reads_rt_s = 1'b1;
        end
        OP_ADDI: begin
          dec_ex_s = {1'b0, ALUOP_W'(2'd0), 1'b1};
          dec_wb_s = 2'b10;
        end
        OP_SLTI: begin
          dec_ex_s = {1'b0, ALUOP_W'(2'd3), 1'b1};
          dec_wb_s = 2'b10;
        end
        default: begin
          dec_illegal_s = 1'b1;
        end
      endcase
    end else begin
      dec_illegal_s = 1'b0;
    end
  end

  // Load-use detection against the load sitting in EX; a flush or reset masks the stall.
  always_comb begin
    hazard_s = id_valid && idex_m_r[1] && (idex_rt_r != '0) &&
               ((idex_rt_r == id_rs) || ((idex_rt_r == id_rt) && reads_rt_s));
    if (rst || branch_taken) begin
      stall_s = 1'b0;
    end else begin
      stall_s = hazard_s;
    end
  end

  // Control pipeline registers and saturating counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      idex_ex_r      <= '0;
      idex_m_r       <= 3'b000;
      idex_wb_r      <= 2'b00;
      idex_rt_r      <= '0;
      idex_illegal_r <= 1'b0;
      exmem_m_r      <= 3'b000;
      exmem_wb_r     <= 2'b00;
      memwb_wb_r     <= 2'b00;
      stall_count_r  <= '0;
      flush_count_r  <= '0;
    end else begin
      if (branch_taken) begin
        idex_ex_r      <= '0;
        idex_m_r       <= 3'b000;
        idex_wb_r      <= 2'b00;
        idex_rt_r      <= '0;
        idex_illegal_r <= 1'b0;
        exmem_m_r      <= 3'b000;
        exmem_wb_r     <= 2'b00;
      end else if (stall_s) begin
        idex_ex_r      <= '0;
        idex_m_r       <= 3'b000;
        idex_wb_r      <= 2'b00;
        idex_rt_r      <= '0;
        idex_illegal_r <= 1'b0;
        exmem_m_r      <= idex_m_r;
        exmem_wb_r     <= idex_wb_r;
      end else begin
        idex_ex_r      <= dec_ex_s;
        idex_m_r       <= dec_m_s;
        idex_wb_r      <= dec_wb_s;
        idex_rt_r      <= id_valid ? id_rt : '0;
        idex_illegal_r <= dec_illegal_s;
        exmem_m_r      <= idex_m_r;
        exmem_wb_r     <= idex_wb_r;
      end
      // The branch itself is in MEM, so MEM/WB always advances.
      memwb_wb_r <= exmem_wb_r;
      if (stall_s && (stall_count_r != {CNT_W{1'b1}})) begin
        stall_count_r <= stall_count_r + CNT_W'(1);
      end else begin
        stall_count_r <= stall_count_r;
      end
      if (branch_taken && (flush_count_r != {CNT_W{1'b1}})) begin
        flush_count_r <= flush_count_r + CNT_W'(1);
      end else begin
        flush_count_r <= flush_count_r;
      end
    end
  end

  assign ex_ctrl     = idex_ex_r;
  assign ex_rt       = idex_rt_r;
  assign mem_ctrl    = exmem_m_r;
  assign wb_ctrl     = memwb_wb_r;
  assign illegal_op  = idex_illegal_r;
  assign stall       = stall_s;
  assign ifid_flush  = branch_taken;
  assign stall_count = stall_count_r;
  assign flush_count = flush_count_r;

endmodule

// File: tb/tb_pipe_control.sv
// Directed self-checking bench for pipe_control (ALUOP_W=2, REG_W=5, CNT_W=2).
module tb_pipe_control;

  localparam int ALUOP_W = 2;
  localparam int REG_W   = 5;
  localparam int CNT_W   = 2;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_SLTI = 6'b001010;
  localparam logic [5:0] OP_BAD  = 6'b111111;

  logic               clk = 1'b0;
  logic               rst;
  logic               id_valid;
  logic [5:0]         id_op;
  logic [REG_W-1:0]   id_rs;
  logic [REG_W-1:0]   id_rt;
  logic               branch_taken;
  logic [ALUOP_W+1:0] ex_ctrl;
  logic [REG_W-1:0]   ex_rt;
  logic [2:0]         mem_ctrl;
  logic [1:0]         wb_ctrl;
  logic               stall;
  logic               ifid_flush;
  logic               illegal_op;
  logic [CNT_W-1:0]   stall_count;
  logic [CNT_W-1:0]   flush_count;

  int checks = 0;
  int errors = 0;

  pipe_control #(.ALUOP_W(ALUOP_W), .REG_W(REG_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_op(id_op), .id_rs(id_rs),
    .id_rt(id_rt), .branch_taken(branch_taken), .ex_ctrl(ex_ctrl), .ex_rt(ex_rt),
    .mem_ctrl(mem_ctrl), .wb_ctrl(wb_ctrl), .stall(stall), .ifid_flush(ifid_flush),
    .illegal_op(illegal_op), .stall_count(stall_count), .flush_count(flush_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt);
    id_valid = v;
    id_op    = op;
    id_rs    = rs;
    id_rt    = rt;
  endtask

  task automatic do_reset();
    drive(1'b0, 6'd0, 5'd0, 5'd0);
    branch_taken = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  logic [5:0] sl_op  [6] = '{OP_R, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_SLTI};
  logic [4:0] sl_rt  [6] = '{5'd2, 5'd3, 5'd2, 5'd2, 5'd4, 5'd4};
  logic [3:0] sl_ex  [6] = '{4'b1100, 4'b0001, 4'b0001, 4'b0010, 4'b0001, 4'b0111};
  logic [2:0] sl_mem [6] = '{3'b000, 3'b010, 3'b001, 3'b100, 3'b000, 3'b000};
  logic [1:0] sl_wb  [6] = '{2'b10, 2'b11, 2'b00, 2'b00, 2'b10, 2'b10};

  initial begin
    rst = 1'b1;
    branch_taken = 1'b0;
    drive(1'b0, 6'd0, 5'd0, 5'd0);
    tick();
    tick();
    rst = 1'b0;
    chk("rst_ex", 32'(ex_ctrl), 32'd0);
    chk("rst_mem", 32'(mem_ctrl), 32'd0);
    chk("rst_wb", 32'(wb_ctrl), 32'd0);

    // Reset mid-pipeline: three loads, then reset while a hazard is presented.
    drive(1'b1, OP_LW, 5'd1, 5'd2); tick();
    drive(1'b1, OP_LW, 5'd3, 5'd4); tick();
    drive(1'b1, OP_LW, 5'd1, 5'd2); tick();
    drive(1'b1, OP_LW, 5'd2, 5'd3);
    rst = 1'b1;
    #1;
    chk("rst_stall_during", 32'(stall), 32'd0);
    tick();
    rst = 1'b0;
    drive(1'b0, 6'd0, 5'd0, 5'd0);
    #1;
    chk("rst2_ex", 32'(ex_ctrl), 32'd0);
    chk("rst2_ex_rt", 32'(ex_rt), 32'd0);
    chk("rst2_mem", 32'(mem_ctrl), 32'd0);
    chk("rst2_wb", 32'(wb_ctrl), 32'd0);
    chk("rst2_illegal", 32'(illegal_op), 32'd0);
    chk("rst2_stall", 32'(stall), 32'd0);
    chk("rst2_scnt", 32'(stall_count), 32'd0);
    chk("rst2_fcnt", 32'(flush_count), 32'd0);

    // Straight-line sequence through all three stages.
    for (int i = 0; i < 9; i++) begin
      if (i < 6) drive(1'b1, sl_op[i], 5'd1, sl_rt[i]);
      else drive(1'b0, 6'd0, 5'd0, 5'd0);
      #1;
      chk("sl_stall", 32'(stall), 32'd0);
      tick();
      if (i < 6) chk("sl_ex", 32'(ex_ctrl), 32'(sl_ex[i]));
      if (i >= 1 && i <= 6) chk("sl_mem", 32'(mem_ctrl), 32'(sl_mem[i-1]));
      if (i >= 2 && i <= 7) chk("sl_wb", 32'(wb_ctrl), 32'(sl_wb[i-2]));
    end

    // Load-use: lw rt=5 then R-type rs=5 rt=7.
    do_reset();
    drive(1'b1, OP_LW, 5'd1, 5'd5);
    #1;
    chk("lu_nostall_lw", 32'(stall), 32'd0);
    tick();
    chk("lu_ex_lw", 32'(ex_ctrl), 32'b0001);
    chk("lu_ex_rt", 32'(ex_rt), 32'd5);
    drive(1'b1, OP_R, 5'd5, 5'd7);
    #1;
    chk("lu_stall", 32'(stall), 32'd1);
    tick();
    chk("lu_bubble_ex", 32'(ex_ctrl), 32'd0);
    chk("lu_bubble_rt", 32'(ex_rt), 32'd0);
    chk("lu_mem_lw", 32'(mem_ctrl), 32'b010);
    chk("lu_scnt", 32'(stall_count), 32'd1);
    chk("lu_stall_once", 32'(stall), 32'd0);
    tick();
    chk("lu_ex_r", 32'(ex_ctrl), 32'b1100);
    chk("lu_ex_rt_r", 32'(ex_rt), 32'd7);
    chk("lu_mem_bubble", 32'(mem_ctrl), 32'd0);
    chk("lu_wb_lw", 32'(wb_ctrl), 32'b11);
    drive(1'b0, 6'd0, 5'd0, 5'd0);
    tick();
    chk("lu_scnt_hold", 32'(stall_count), 32'd1);

    // Non-hazards: rt=0 load, and addi not reading rt; then sw reading rt does stall.
    do_reset();
    drive(1'b1, OP_LW, 5'd1, 5'd0); tick();
    drive(1'b1, OP_R, 5'd0, 5'd0);
    #1;
    chk("nh_rt0", 32'(stall), 32'd0);
    tick();
    drive(1'b1, OP_LW, 5'd1, 5'd5); tick();
    drive(1'b1, OP_ADDI, 5'd3, 5'd5);
    #1;
    chk("nh_addi", 32'(stall), 32'd0);
    tick();
    drive(1'b1, OP_LW, 5'd1, 5'd5); tick();
    drive(1'b1, OP_SW, 5'd3, 5'd5);
    #1;
    chk("hz_sw_rt", 32'(stall), 32'd1);
    tick();
    drive(1'b0, 6'd0, 5'd0, 5'd0);

    // Flush wins over a simultaneous load-use hazard.
    do_reset();
    drive(1'b1, OP_LW, 5'd1, 5'd5); tick();
    drive(1'b1, OP_R, 5'd5, 5'd7);
    branch_taken = 1'b1;
    #1;
    chk("fl_stall", 32'(stall), 32'd0);
    chk("fl_ifid", 32'(ifid_flush), 32'd1);
    tick();
    branch_taken = 1'b0;
    drive(1'b0, 6'd0, 5'd0, 5'd0);
    chk("fl_ex", 32'(ex_ctrl), 32'd0);
    chk("fl_ex_rt", 32'(ex_rt), 32'd0);
    chk("fl_mem", 32'(mem_ctrl), 32'd0);
    chk("fl_fcnt", 32'(flush_count), 32'd1);
    chk("fl_scnt", 32'(stall_count), 32'd0);

    // The instruction in MEM still retires during a flush.
    do_reset();
    drive(1'b1, OP_ADDI, 5'd1, 5'd2); tick();
    drive(1'b0, 6'd0, 5'd0, 5'd0); tick();
    branch_taken = 1'b1;
    tick();
    branch_taken = 1'b0;
    chk("fl_wb_retire", 32'(wb_ctrl), 32'b10);

    // Illegal opcode, then the same opcode with id_valid low.
    do_reset();
    drive(1'b1, OP_BAD, 5'd0, 5'd0); tick();
    drive(1'b0, OP_BAD, 5'd0, 5'd0);
    chk("ill_flag", 32'(illegal_op), 32'd1);
    chk("ill_ex", 32'(ex_ctrl), 32'd0);
    tick();
    chk("ill_pulse", 32'(illegal_op), 32'd0);
    chk("ill_mem", 32'(mem_ctrl), 32'd0);
    tick();
    chk("ill_wb", 32'(wb_ctrl), 32'd0);
    chk("ill_invalid", 32'(illegal_op), 32'd0);

    // Five load-use stalls saturate a 2-bit counter at 3.
    do_reset();
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, OP_LW, 5'd1, 5'd5); tick();
      drive(1'b1, OP_R, 5'd5, 5'd7); tick();
      tick();
    end
    drive(1'b0, 6'd0, 5'd0, 5'd0);
    tick();
    chk("sat_scnt", 32'(stall_count), 32'd3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_control.md
# pipe_control

Pipelined MIPS main control unit. Decodes the opcode in ID into EX/M/WB control bundles and carries them through the ID/EX, EX/MEM and MEM/WB control registers. Detects load-use hazards and inserts a bubble with a stall request. Squashes younger instructions on a taken branch. Sits beside the datapath pipeline registers and replaces the purely combinational opcode decoder.

## Interface
- `ALUOP_W`, default 2: ALUOp field width (≥2). Codes are zero-extended into it.
- `REG_W`, default 5: register-address width.
- `CNT_W`, default 16: width of the stall/flush performance counters.
- `clk` in 1: the only clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `id_valid` in 1: the IF/ID register holds a real instruction.
- `id_op` in 6: opcode `[31:26]` of the ID instruction.
- `id_rs`, `id_rt` in `REG_W`: source fields of the ID instruction.
- `branch_taken` in 1: the MEM-stage beq resolved taken this cycle.
- `ex_ctrl` out `ALUOP_W+2`: {RegDst, ALUOp, ALUSrc}, from ID/EX.
- `ex_rt` out `REG_W`: rt of the instruction now in EX.
- `mem_ctrl` out 3: {Branch, MemRead, MemWrite}, from EX/MEM.
- `wb_ctrl` out 2: {RegWrite, MemtoReg}, from MEM/WB.
- `stall` out 1: combinational. Hold PC and IF/ID this cycle.
- `ifid_flush` out 1: combinational. Equals `branch_taken`; the external IF/ID register clears.
- `illegal_op` out 1: registered. Pulses one cycle in EX for an unknown opcode with `id_valid`.
- `stall_count`, `flush_count` out `CNT_W`: saturating event counters.

## Operation
- Decode (combinational, in ID):
  - R-type 000000: RegDst=1, ALUOp=2, ALUSrc=0, M=000, WB=10.
  - lw 100011: RegDst=0, ALUOp=0, ALUSrc=1, M=010, WB=11.
  - sw 101011: ALUOp=0, ALUSrc=1, M=001, WB=00.
  - beq 000100: ALUOp=1, ALUSrc=0, M=100, WB=00.
  - addi 001000: ALUOp=0, ALUSrc=1, M=000, WB=10.
  - slti 001010: ALUOp=3, ALUSrc=1, M=000, WB=10.
  - Any other opcode: all bundles zero; flags illegal.
  - `id_valid`=0: all bundles zero, no illegal flag.
- rt-reading ops are R-type, sw and beq. Only rs is read by lw, addi and slti.
- Load-use hazard: asserts when all of the following hold:
  - `id_valid`=1;
  - ID/EX MemRead=1;
  - `ex_rt`≠0;
  - `ex_rt`==`id_rs`, or (`ex_rt`==`id_rt` and the op reads rt).
- On a hazard, `stall`=1 and ID/EX loads a bubble (all zero). The ID instruction re-presents next cycle and is not lost.
- Flush: when `branch_taken`=1, ID/EX and EX/MEM load zero, squashing the instructions in ID and EX. MEM/WB loads normally, so the branch itself retires.
- Priority: flush > stall. When `branch_taken`=1, `stall`=0.
- Non-flushed EX/MEM and MEM/WB stages always advance. There is no back-pressure beyond ID.
- `ex_rt` is reset to 0 with the bubble/flush.
- Counters:
  - `stall_count` increments on each cycle with `stall`=1.
  - `flush_count` increments on each cycle with `branch_taken`=1.
  - Both saturate at 2^`CNT_W`−1 and do not wrap.

## Timing
- Instruction in ID at cycle n (no stall/flush):
  - `ex_ctrl` valid n+1;
  - `mem_ctrl` valid n+2;
  - `wb_ctrl` valid n+3.
- `stall` and `ifid_flush` are same-cycle combinational from inputs and ID/EX state.
- A load-use stall lasts exactly 1 cycle. The next cycle, ID/EX holds the bubble, so the hazard term is false.
- Reset is synchronous on the rising edge with `rst`=1. It overrides every other event, including a simultaneous flush or stall.
- After reset, all registered outputs are 0:
  - `ex_ctrl`, `ex_rt`, `mem_ctrl`, `wb_ctrl`, `illegal_op` and both counters.
  - `stall` is 0 during reset.
- Reset mid-pipeline discards all in-flight control. The first post-reset cycle behaves as an empty pipe.
- `branch_taken` and a hazard in the same cycle: flush only. `stall_count` is unchanged; `flush_count` increments.

## Test plan
- Reset: drive lw for 3 cycles, then `rst`=1 for 1 cycle. Required: all outputs 0 the next cycle and counters 0.
- Straight-line sequence R-type, lw, sw, beq, addi, slti, ALUOP_W=2. Required `ex_ctrl` at n+1: 1100, 0001, 0001, 0010, 0001, 0111.
  - `mem_ctrl` at n+2: 000, 010, 001, 100, 000, 000.
  - `wb_ctrl` at n+3: 10, 11, 00, 00, 10, 10.
- Load-use: lw rt=5, then R-type rs=5 rt=7. Required:
  - `stall`=1 for exactly one cycle, bubble in EX (`ex_ctrl`=0);
  - the R-type appears in EX one cycle late;
  - `stall_count`=1.
- Non-hazard cases, each requiring `stall`=0:
  - lw rt=0 followed by R-type rs=0;
  - lw rt=5 followed by addi rt=5 rs=3 (addi does not read rt).
- Flush: `branch_taken`=1 while lw is in EX and a hazardous consumer is in ID. Required:
  - `stall`=0, `ifid_flush`=1;
  - the next cycle, `ex_ctrl`=0 and `mem_ctrl`=0;
  - `flush_count`=1.
- Illegal opcode 111111 with `id_valid`=1: `illegal_op`=1 for one cycle, all bundles 0. With CNT_W=2 and 5 stalls, `stall_count` saturates at 3.
